dadda_mac_seq: RTL and testbench
================================

Name: dadda_mac_seq

Overview:
- Sequential multiply-accumulate front end for the combinational dadda_8_bit_mul (a[7:0], b[7:0], acc[15:0] -> p[16:0] = a*b+acc).
- Accepts a stream of 8-bit operand pairs over a valid/ready handshake and drives the multiplier's a/b/acc inputs from registers.
- Captures p back into a 16-bit saturating accumulator and emits one dot-product result every LEN pairs.
- Sits directly upstream of the multiplier and directly downstream of it: it both feeds it and consumes its output.

Parameters:
- LEN, 4, operand pairs per dot product; legal range 1..2^CNT_W-1; LEN=0 is illegal.
- CNT_W, 8, width of the internal pair counter.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a frame; sampled only in IDLE.
- bias  input  16  initial accumulator value; captured with start.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair.
- in_a  input  8  operand a.
- in_b  input  8  operand b.
- mul_a  output  8  to multiplier a; registered.
- mul_b  output  8  to multiplier b; registered.
- mul_acc  output  16  to multiplier acc; registered.
- mul_p  input  17  from multiplier p.
- out_valid  output  1  result valid.
- out_ready  input  1  result consumer ready.
- out_sum  output  16  saturated dot product.
- out_ovf  output  1  sticky: saturation occurred in this frame.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE.
  - acc_r, a_r, b_r, cnt and ovf_r clear to 0.
  - All outputs read 0 after the edge, including in_ready, out_valid, out_sum, out_ovf, busy, mul_*.
  - Reset has priority over every other input and aborts any frame in progress; no partial result is emitted.
- Output mapping:
  - mul_a=a_r, mul_b=b_r, mul_acc=acc_r at all times.
  - out_sum=acc_r and out_ovf=ovf_r; both are only meaningful while out_valid=1.
- State IDLE:
  - in_ready=0, out_valid=0.
  - start=1: acc_r<=bias, cnt<=0, ovf_r<=0, go to RUN.
- State RUN:
  - in_ready=1.
  - in_valid=1 (transfer): a_r<=in_a, b_r<=in_b, go to MUL.
  - in_valid=0: remain in RUN; gaps of any length are allowed.
- State MUL (exactly one cycle):
  - in_ready=0.
  - The multiplier sees the registered operands and acc_r; mul_p is treated as settled within the cycle.
  - At the edge: if mul_p[16]=1, acc_r<=16'hFFFF and ovf_r<=1; otherwise acc_r<=mul_p[15:0].
  - cnt<=cnt+1.
  - If cnt==LEN-1, go to DONE; otherwise go to RUN.
- State DONE:
  - out_valid=1, with out_sum and out_ovf held stable.
  - out_ready=1: go to IDLE at that edge.
  - out_ready=0: hold indefinitely.
- Saturation:
  - Once acc_r is 16'hFFFF, any further product with a*b>0 overflows again and the value stays at 16'hFFFF.
  - a*b=0 leaves acc_r unchanged.
  - ovf_r never clears mid-frame.
- Throughput and latency:
  - Throughput is one pair per 2 cycles.
  - The last pair is accepted at edge k; acc_r is updated and out_valid rises after edge k+1.
  - Minimum frame length is 1 + 2*LEN + 1 cycles, counting IDLE->RUN through the DONE handshake.
- Ignored inputs:
  - start outside IDLE is ignored, with no effect on acc_r or cnt.
  - in_valid outside RUN is ignored, and the data is not captured.
- DONE->IDLE->RUN needs at least one IDLE cycle, so start is ignored in the DONE cycle itself, even when out_ready=1.
- Counter: cnt wraps only through frame restart and never exceeds LEN-1 in RUN.

Test Plan:
- LEN=1, bias=16'h0F0F, pair (8'hFF,8'hFF): mul_p=17'h10D10, so out_sum=16'hFFFF and out_ovf=1, with out_valid exactly 2 cycles after acceptance.
- LEN=4, bias=0, pairs (1,2),(3,4),(5,6),(7,8) sent back-to-back: out_sum=16'h0064 (100), out_ovf=0; in_ready toggles 1,0 each pair.
- LEN=4, bias=16'h0010, same pairs with in_valid gaps of 0,3,1 cycles: out_sum=16'h0074 and cycle count grows by exactly 4.
- Backpressure: hold out_ready=0 for 5 cycles in DONE; out_valid, out_sum and out_ovf stay stable; start pulsed during DONE is ignored; release returns to IDLE, and the next start with bias=0 yields a clean frame with out_ovf=0.
- Reset mid-frame: assert rst in MUL after 2 of 4 pairs; the next cycle shows all outputs at 0 and IDLE; a new frame computes correctly from bias with no residue.
- start pulsed in RUN with bias=16'hAAAA is ignored (acc_r unchanged); in_valid asserted in IDLE with data is not captured.

Source files
------------

// File: rtl/dadda_mac_seq.sv
// dadda_mac_seq: sequential multiply-accumulate front end for a combinational
// a*b+acc multiplier. Streams LEN operand pairs per frame into a 16-bit
// saturating accumulator and presents one dot-product result per frame.
module dadda_mac_seq #(
  parameter int LEN   = 4,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] bias,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  output logic [15:0] mul_acc,
  input  logic [16:0] mul_p,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_sum,
  output logic        out_ovf,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Index of the final pair; reaching it in MUL ends the frame.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  state_e           state_q, state_d;
  logic [15:0]      acc_q, acc_d;
  logic [7:0]       a_q, a_d;
  logic [7:0]       b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  // State and datapath registers; reset wins over everything and drops any frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and datapath update; everything holds unless a state acts on it.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = bias;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          state_d = MUL;
        end
      end
      MUL: begin
        // Carry out of the 16-bit sum clamps the accumulator; ovf is sticky.
        if (mul_p[16]) begin
          acc_d = 16'hFFFF;
          ovf_d = 1'b1;
        end else begin
          acc_d = mul_p[15:0];
        end
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == LAST) ? DONE : RUN;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are straight decodes of state and registers, so all read 0 after reset.
  always_comb begin
    in_ready  = (state_q == RUN);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    mul_a     = a_q;
    mul_b     = b_q;
    mul_acc   = acc_q;
    out_sum   = acc_q;
    out_ovf   = ovf_q;
  end

endmodule

// File: tb/tb_dadda_mac_seq.sv
// Bench for dadda_mac_seq: a LEN=4 instance driven by directed and random
// frames, plus a LEN=1 instance for the single-pair saturation case.
module tb_dadda_mac_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // LEN=4 instance
  logic        start0, iv0, ir0, ov0, or0, ovf0, busy0;
  logic [15:0] bias0, macc0, sum0;
  logic [7:0]  ia0, ib0, ma0, mb0;
  logic [16:0] mp0;
  assign mp0 = {9'b0, ma0} * {9'b0, mb0} + {1'b0, macc0};

  dadda_mac_seq #(.LEN(4), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .start(start0), .bias(bias0),
    .in_valid(iv0), .in_ready(ir0), .in_a(ia0), .in_b(ib0),
    .mul_a(ma0), .mul_b(mb0), .mul_acc(macc0), .mul_p(mp0),
    .out_valid(ov0), .out_ready(or0), .out_sum(sum0), .out_ovf(ovf0),
    .busy(busy0)
  );

  // LEN=1 instance
  logic        start1, iv1, ir1, ov1, or1, ovf1, busy1;
  logic [15:0] bias1, macc1, sum1;
  logic [7:0]  ia1, ib1, ma1, mb1;
  logic [16:0] mp1;
  assign mp1 = {9'b0, ma1} * {9'b0, mb1} + {1'b0, macc1};

  dadda_mac_seq #(.LEN(1), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .start(start1), .bias(bias1),
    .in_valid(iv1), .in_ready(ir1), .in_a(ia1), .in_b(ib1),
    .mul_a(ma1), .mul_b(mb1), .mul_acc(macc1), .mul_p(mp1),
    .out_valid(ov1), .out_ready(or1), .out_sum(sum1), .out_ovf(ovf1),
    .busy(busy1)
  );

  int tests = 0;
  int fails = 0;

  int pa[4], pb[4], gap[4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: saturating dot product, plain integer arithmetic.
  function automatic logic [16:0] model(input int bias_v);
    int  acc;
    bit  ovf;
    acc = bias_v;
    ovf = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (acc + pa[i] * pb[i] > 65535) begin
        acc = 65535;
        ovf = 1'b1;
      end else begin
        acc = acc + pa[i] * pb[i];
      end
    end
    return {ovf, acc[15:0]};
  endfunction

  // Run one LEN=4 frame up to DONE. Gap cycles optionally carry a stray start
  // with a junk bias, which must be ignored.
  task automatic do_frame(input string tag, input logic [15:0] b, input bit noise,
                          input bit chk_cyc);
    logic [16:0] exp;
    int cyc, n, gsum;
    exp  = model(int'(b));
    gsum = 0;
    start0 = 1'b1; bias0 = b; tick(); start0 = 1'b0; cyc = 1;
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gap[i]; g++) begin
        start0 = noise; bias0 = 16'hAAAA;
        tick(); cyc++;
      end
      start0 = 1'b0;
      gsum += gap[i];
      n = 0;
      while (!ir0 && n < 20) begin tick(); n++; end
      chk({tag, " in_ready_run"}, ir0, 1'b1);
      iv0 = 1'b1; ia0 = 8'(pa[i]); ib0 = 8'(pb[i]);
      tick(); cyc++;
      iv0 = 1'b0; ia0 = $urandom; ib0 = $urandom;
      if (i == 0) chk({tag, " in_ready_mul"}, ir0, 1'b0);
      tick(); cyc++;
    end
    chk({tag, " out_valid"}, ov0, 1'b1);
    chk({tag, " out_sum"}, sum0, exp[15:0]);
    chk({tag, " out_ovf"}, ovf0, exp[16]);
    if (chk_cyc) chk({tag, " cycles"}, cyc, 1 + 2 * 4 + gsum);
  endtask

  // Hold the result for `hold` cycles (checking stability), then hand it off.
  task automatic finish_frame(input string tag, input int hold, input bit poke_start);
    logic [15:0] s;
    logic        o;
    s = sum0; o = ovf0;
    or0 = 1'b0;
    for (int h = 0; h < hold; h++) begin
      start0 = poke_start; bias0 = 16'h1234;
      tick();
      start0 = 1'b0;
      if (h == hold - 1) begin
        chk({tag, " hold_valid"}, ov0, 1'b1);
        chk({tag, " hold_sum"}, sum0, s);
        chk({tag, " hold_ovf"}, ovf0, o);
      end
    end
    or0 = 1'b1; start0 = poke_start;
    tick();
    or0 = 1'b0; start0 = 1'b0;
    chk({tag, " back_idle"}, {busy0, ov0}, 2'b00);
  endtask

  initial begin
    start0 = 0; iv0 = 0; or0 = 0; bias0 = 0; ia0 = 0; ib0 = 0;
    start1 = 0; iv1 = 0; or1 = 0; bias1 = 0; ia1 = 0; ib1 = 0;

    // Reset
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst outs", {ir0, ov0, ovf0, busy0}, 4'b0);
    chk("rst sum", sum0, 16'h0);
    chk("rst mul", {ma0, mb0, macc0}, 32'h0);

    // in_valid in IDLE is not captured
    iv0 = 1'b1; ia0 = 8'h55; ib0 = 8'h66; tick(); iv0 = 1'b0;
    chk("idle iv ignored", {ma0, mb0}, 16'h0);
    chk("idle stays", {busy0, ir0}, 2'b00);

    // LEN=1: saturating single pair; out_valid two edges after acceptance
    start1 = 1'b1; bias1 = 16'h0F0F; tick(); start1 = 1'b0;
    iv1 = 1'b1; ia1 = 8'hFF; ib1 = 8'hFF; tick(); iv1 = 1'b0;
    chk("len1 mul_p", mp1, 17'h10D10);
    chk("len1 not yet valid", ov1, 1'b0);
    tick();
    chk("len1 valid", ov1, 1'b1);
    chk("len1 sum", sum1, 16'hFFFF);
    chk("len1 ovf", ovf1, 1'b1);
    or1 = 1'b1; tick(); or1 = 1'b0;
    chk("len1 idle", busy1, 1'b0);

    // Back-to-back (1,2),(3,4),(5,6),(7,8)
    pa = '{1, 3, 5, 7}; pb = '{2, 4, 6, 8}; gap = '{0, 0, 0, 0};
    do_frame("b2b", 16'h0000, 1'b0, 1'b1);
    chk("b2b sum100", sum0, 16'h0064);
    finish_frame("b2b", 1, 1'b0);

    // Gaps 0,3,1 plus stray start with bias AAAA during gaps
    gap = '{0, 3, 1, 0};
    do_frame("gap", 16'h0010, 1'b1, 1'b1);
    chk("gap sum116", sum0, 16'h0074);
    finish_frame("gap", 1, 1'b0);

    // Saturating frame with backpressure and start poked in DONE
    pa = '{255, 255, 255, 255}; pb = '{255, 255, 0, 255}; gap = '{0, 0, 0, 0};
    do_frame("bp", 16'h0000, 1'b0, 1'b0);
    finish_frame("bp", 5, 1'b1);
    pa = '{2, 0, 9, 10}; pb = '{3, 200, 9, 11};
    do_frame("clean", 16'h0000, 1'b0, 1'b1);
    chk("clean ovf", ovf0, 1'b0);
    finish_frame("clean", 1, 1'b0);

    // Reset while in MUL after 2 pairs
    start0 = 1'b1; bias0 = 16'h0100; tick(); start0 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      iv0 = 1'b1; ia0 = 8'h40; ib0 = 8'h40; tick(); iv0 = 1'b0; tick();
    end
    iv0 = 1'b1; tick(); iv0 = 1'b0;
    chk("pre-rst in MUL", {busy0, ir0, ov0}, 3'b100);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid rst outs", {ir0, ov0, ovf0, busy0}, 4'b0);
    chk("mid rst data", {macc0, ma0, mb0}, 32'h0);
    pa = '{10, 20, 30, 40}; pb = '{1, 2, 3, 4}; gap = '{1, 0, 2, 0};
    do_frame("post rst", 16'h0005, 1'b0, 1'b1);
    finish_frame("post rst", 2, 1'b0);

    // Randomized frames
    for (int f = 0; f < 30; f++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 3) == 0) pa[i] = 0;
        else pa[i] = (f % 2) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 40));
        pb[i] = $urandom_range(0, 255);
        gap[i] = $urandom_range(0, 3);
      end
      do_frame("rand", 16'($urandom), 1'($urandom), 1'b1);
      finish_frame("rand", $urandom_range(1, 4), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
